memory_stage: RTL and testbench

- Pipeline stage directly downstream of execute_stage and upstream of writeback.
- Takes the registered execute result (ALU result or effective address) plus load/store control.
- Issues word-aligned data-memory requests over a valid/ready request and valid response handshake, and performs byte-lane steering and load sign/zero extension.
- Registers the write-back bundle and stalls upstream stages while a memory access is outstanding.

---
 rtl/memory_stage.sv | 214 +++++++++++++++++++++
 tb/tb_memory_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory stage: issues aligned data-memory requests, steers store lanes,
// extends load data and registers the write-back bundle.
module memory_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              execute_memory_v,
  input  logic [REG_W-1:0]  execute_memory_rs1,
  input  logic [REG_W-1:0]  execute_memory_rs2,
  input  logic [REG_W-1:0]  execute_memory_rd,
  input  logic              execute_memory_rd_w_v,
  input  logic [WORD_W-1:0] execute_memory_result,
  input  logic [WORD_W-1:0] execute_memory_rs2_data,
  input  logic              execute_memory_ld_v,
  input  logic              execute_memory_st_v,
  input  logic [2:0]        execute_memory_ldop,
  input  logic [1:0]        execute_memory_strop,
  output logic              memory_stall,
  output logic              dmem_req_v,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [WORD_W-1:0] dmem_req_addr,
  output logic [WORD_W-1:0] dmem_req_wdata,
  output logic [3:0]        dmem_req_wmask,
  input  logic              dmem_resp_v,
  input  logic [WORD_W-1:0] dmem_resp_data,
  output logic              memory_writeback_v,
  output logic [REG_W-1:0]  memory_writeback_rs1,
  output logic [REG_W-1:0]  memory_writeback_rs2,
  output logic [REG_W-1:0]  memory_writeback_rd,
  output logic              memory_writeback_rd_w_v,
  output logic [WORD_W-1:0] memory_writeback_data,
  output logic              memory_writeback_misalign
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t r_state, w_nstate;

  logic [REG_W-1:0]  r_rs1, r_rs2, r_rd;
  logic              r_rd_w_v, r_we;
  logic [WORD_W-1:0] r_addr, r_wdata;
  logic [3:0]        r_wmask;
  logic [2:0]        r_ldop;

  logic              r_wb_v, r_wb_rdw, r_wb_mis;
  logic [REG_W-1:0]  r_wb_rs1, r_wb_rs2, r_wb_rd;
  logic [WORD_W-1:0] r_wb_data;

  logic              w_mem, w_mis, w_stall;
  logic              w_done, w_cap;
  logic [1:0]        w_size;
  logic [WORD_W-1:0] w_wdata, w_lsh, w_ext;
  logic [3:0]        w_wmask;
  logic [REG_W-1:0]  w_d_rs1, w_d_rs2, w_d_rd;
  logic              w_d_rdw, w_d_mis;
  logic [WORD_W-1:0] w_d_data;

  assign w_mem  = execute_memory_ld_v | execute_memory_st_v;
  // load wins when both flags are set
  assign w_size = execute_memory_ld_v ? execute_memory_ldop[1:0]
                                      : execute_memory_strop;
  assign w_mis  = ((w_size == 2'b01) & execute_memory_result[0])
                | (w_size[1] & (|execute_memory_result[1:0]));

  always_comb begin
    w_wdata = execute_memory_rs2_data;
    w_wmask = 4'hf;
    unique case (1'b1)
      (w_size == 2'b00): begin
        w_wdata = {4{execute_memory_rs2_data[7:0]}};
        w_wmask = 4'b0001 << execute_memory_result[1:0];
      end
      (w_size == 2'b01): begin
        w_wdata = {2{execute_memory_rs2_data[15:0]}};
        w_wmask = 4'b0011 << execute_memory_result[1:0];
      end
      default: ;
    endcase
  end

  assign w_lsh = dmem_resp_data >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = dmem_resp_data;
    unique case (1'b1)
      (r_ldop[1:0] == 2'b00):
        w_ext = {{(WORD_W-8){~r_ldop[2] & w_lsh[7]}}, w_lsh[7:0]};
      (r_ldop[1:0] == 2'b01):
        w_ext = {{(WORD_W-16){~r_ldop[2] & w_lsh[15]}}, w_lsh[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    w_stall  = 1'b0;
    w_done   = 1'b0;
    w_cap    = 1'b0;
    w_d_rs1  = r_rs1;
    w_d_rs2  = r_rs2;
    w_d_rd   = r_rd;
    w_d_rdw  = 1'b0;
    w_d_mis  = 1'b0;
    w_d_data = r_addr;
    unique case (r_state)
      S_IDLE: begin
        if (execute_memory_v) begin
          w_d_rs1  = execute_memory_rs1;
          w_d_rs2  = execute_memory_rs2;
          w_d_rd   = execute_memory_rd;
          w_d_data = execute_memory_result;
          if (!w_mem) begin
            w_done  = 1'b1;
            w_d_rdw = execute_memory_rd_w_v;
          end else if (w_mis) begin
            w_done  = 1'b1;
            w_d_mis = 1'b1;
          end else begin
            w_cap    = 1'b1;
            w_stall  = 1'b1;
            w_nstate = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dmem_req_ready && r_we) begin
          w_done   = 1'b1;
          w_nstate = S_IDLE;
        end else begin
          w_stall = 1'b1;
          if (dmem_req_ready) w_nstate = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_resp_v) begin
          w_done   = 1'b1;
          w_d_rdw  = r_rd_w_v;
          w_d_data = w_ext;
          w_nstate = S_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_rd_w_v  <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_ldop    <= '0;
      r_wb_v    <= 1'b0;
      r_wb_rdw  <= 1'b0;
      r_wb_mis  <= 1'b0;
      r_wb_rs1  <= '0;
      r_wb_rs2  <= '0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      r_state <= w_nstate;
      r_wb_v  <= w_done;
      if (w_cap) begin
        r_rs1    <= execute_memory_rs1;
        r_rs2    <= execute_memory_rs2;
        r_rd     <= execute_memory_rd;
        r_rd_w_v <= execute_memory_rd_w_v;
        r_we     <= execute_memory_st_v & ~execute_memory_ld_v;
        r_addr   <= execute_memory_result;
        r_wdata  <= w_wdata;
        r_wmask  <= w_wmask;
        r_ldop   <= execute_memory_ldop;
      end
      if (w_done) begin
        r_wb_rs1  <= w_d_rs1;
        r_wb_rs2  <= w_d_rs2;
        r_wb_rd   <= w_d_rd;
        r_wb_rdw  <= w_d_rdw;
        r_wb_mis  <= w_d_mis;
        r_wb_data <= w_d_data;
      end
    end
  end

  assign memory_stall   = w_stall;
  assign dmem_req_v     = (r_state == S_REQ);
  assign dmem_req_we    = dmem_req_v & r_we;
  assign dmem_req_addr  = dmem_req_v ? {r_addr[WORD_W-1:2], 2'b00} : '0;
  assign dmem_req_wdata = dmem_req_we ? r_wdata : '0;
  assign dmem_req_wmask = dmem_req_we ? r_wmask : 4'h0;

  assign memory_writeback_v        = r_wb_v;
  assign memory_writeback_rs1      = r_wb_rs1;
  assign memory_writeback_rs2      = r_wb_rs2;
  assign memory_writeback_rd       = r_wb_rd;
  assign memory_writeback_rd_w_v   = r_wb_rdw;
  assign memory_writeback_data     = r_wb_data;
  assign memory_writeback_misalign = r_wb_mis;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass, loads, stores,
// misalignment, back-to-back issue and reset abandonment.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v, rd_w_v, ld_v, st_v;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] result, rs2_data;
  logic [2:0]  ldop;
  logic [1:0]  strop;
  logic        stall, req_v, req_ready, req_we, resp_v;
  logic [31:0] req_addr, req_wdata, resp_data;
  logic [3:0]  req_wmask;
  logic        wb_v, wb_rdw, wb_mis;
  logic [4:0]  wb_rs1, wb_rs2, wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk                       (clk),
    .rst                       (rst),
    .execute_memory_v          (v),
    .execute_memory_rs1        (rs1),
    .execute_memory_rs2        (rs2),
    .execute_memory_rd         (rd),
    .execute_memory_rd_w_v     (rd_w_v),
    .execute_memory_result     (result),
    .execute_memory_rs2_data   (rs2_data),
    .execute_memory_ld_v       (ld_v),
    .execute_memory_st_v       (st_v),
    .execute_memory_ldop       (ldop),
    .execute_memory_strop      (strop),
    .memory_stall              (stall),
    .dmem_req_v                (req_v),
    .dmem_req_ready            (req_ready),
    .dmem_req_we               (req_we),
    .dmem_req_addr             (req_addr),
    .dmem_req_wdata            (req_wdata),
    .dmem_req_wmask            (req_wmask),
    .dmem_resp_v               (resp_v),
    .dmem_resp_data            (resp_data),
    .memory_writeback_v        (wb_v),
    .memory_writeback_rs1      (wb_rs1),
    .memory_writeback_rs2      (wb_rs2),
    .memory_writeback_rd       (wb_rd),
    .memory_writeback_rd_w_v   (wb_rdw),
    .memory_writeback_data     (wb_data),
    .memory_writeback_misalign (wb_mis)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic iv, input logic ild, input logic ist,
                    input logic [2:0] ilop, input logic [1:0] isop,
                    input logic [4:0] ird, input logic irdw,
                    input logic [31:0] ires, input logic [31:0] id2);
    v = iv; ld_v = ild; st_v = ist; ldop = ilop; strop = isop;
    rd = ird; rd_w_v = irdw; result = ires; rs2_data = id2;
    rs1 = 5'd1; rs2 = 5'd2;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    idle();
    req_ready = 1'b0; resp_v = 1'b0; resp_data = '0;
    #3;
    total++;
    if ({wb_v, wb_rdw, wb_mis, wb_rd, wb_data} !== '0) begin
      bad++; $display("FAIL reset_wb got=%0h exp=0", {wb_v, wb_rd, wb_data});
    end
    total++;
    if ({stall, req_v, req_we, req_addr, req_wmask} !== '0) begin
      bad++; $display("FAIL reset_req got=%0h exp=0", {stall, req_v, req_addr});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_alu();
    tick();
    op(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 5'd5, 1'b1, 32'h12345678, 32'h0);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%0b exp=0", stall); end
    tick();
    idle();
    total++;
    if ({wb_v, wb_rd, wb_rdw, wb_mis} !== {1'b1, 5'd5, 1'b1, 1'b0}) begin
      bad++; $display("FAIL alu_ctl got=%0b/%0d/%0b/%0b exp=1/5/1/0", wb_v, wb_rd, wb_rdw, wb_mis);
    end
    total++;
    if (wb_data !== 32'h12345678) begin
      bad++; $display("FAIL alu_data got=%08h exp=12345678", wb_data);
    end
    total++;
    if ({wb_rs1, wb_rs2} !== {5'd1, 5'd2}) begin
      bad++; $display("FAIL alu_idx got=%0d/%0d exp=1/2", wb_rs1, wb_rs2);
    end
    tick();
    total++;
    if (wb_v !== 1'b0) begin bad++; $display("FAIL alu_vdrop got=%0b exp=0", wb_v); end
  endtask

  task automatic test_lb();
    op(1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 5'd7, 1'b1, 32'h103, 32'h0);
    req_ready = 1'b1;
    resp_data = 32'h80FF_0000;
    #1;
    total++;
    if ({stall, req_v} !== 2'b10) begin
      bad++; $display("FAIL lb_accept got=%0b%0b exp=10", stall, req_v);
    end
    tick();
    total++;
    if ({stall, req_v, req_we, wb_v} !== 4'b1100) begin
      bad++; $display("FAIL lb_req got=%04b exp=1100", {stall, req_v, req_we, wb_v});
    end
    total++;
    if (req_addr !== 32'h100) begin
      bad++; $display("FAIL lb_addr got=%08h exp=00000100", req_addr);
    end
    tick();
    resp_v = 1'b1;
    #1;
    total++;
    if ({stall, req_v, wb_v} !== 3'b000) begin
      bad++; $display("FAIL lb_wait got=%03b exp=000", {stall, req_v, wb_v});
    end
    tick();
    idle();
    resp_v = 1'b0;
    total++;
    if ({wb_v, wb_rdw, wb_mis, wb_rd} !== {3'b110, 5'd7}) begin
      bad++; $display("FAIL lb_ctl got=%0b%0b%0b/%0d exp=110/7", wb_v, wb_rdw, wb_mis, wb_rd);
    end
    total++;
    if (wb_data !== 32'hFFFFFF80) begin
      bad++; $display("FAIL lb_data got=%08h exp=ffffff80", wb_data);
    end
  endtask

  task automatic test_sh_backpressure();
    tick();
    op(1'b1, 1'b0, 1'b1, 3'd0, 2'b01, 5'd3, 1'b1, 32'h202, 32'hAAAA_BEEF);
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({stall, req_v, req_we, req_wmask, req_wdata, req_addr} !==
          {3'b111, 4'b1100, 32'hBEEFBEEF, 32'h200}) begin
        bad++; $display("FAIL sh_hold%0d got=%0b%0b%0b %04b %08h %08h exp=111 1100 beefbeef 00000200",
                        i, stall, req_v, req_we, req_wmask, req_wdata, req_addr);
      end
    end
    tick();
    req_ready = 1'b1;
    #1;
    total++;
    if ({stall, req_v, wb_v} !== 3'b010) begin
      bad++; $display("FAIL sh_xfer got=%03b exp=010", {stall, req_v, wb_v});
    end
    tick();
    idle();
    req_ready = 1'b0;
    total++;
    if ({wb_v, wb_rdw, wb_mis, req_v} !== 4'b1000 || wb_data !== 32'h202) begin
      bad++; $display("FAIL sh_done got=%04b %08h exp=1000 00000202", {wb_v, wb_rdw, wb_mis, req_v}, wb_data);
    end
  endtask

  task automatic test_misalign();
    tick();
    op(1'b1, 1'b1, 1'b0, 3'b010, 2'd0, 5'd9, 1'b1, 32'h301, 32'h0);
    req_ready = 1'b1;
    #1;
    total++;
    if ({stall, req_v} !== 2'b00) begin
      bad++; $display("FAIL mis_issue got=%0b%0b exp=00", stall, req_v);
    end
    tick();
    idle();
    #1;
    total++;
    if ({wb_v, wb_rdw, wb_mis, req_v} !== 4'b1010 || wb_data !== 32'h301) begin
      bad++; $display("FAIL mis_wb got=%04b %08h exp=1010 00000301", {wb_v, wb_rdw, wb_mis, req_v}, wb_data);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    op(1'b1, 1'b1, 1'b0, 3'b101, 2'd0, 5'd4, 1'b1, 32'h402, 32'h0);
    req_ready = 1'b1;
    resp_data = 32'h8001_0000;
    tick();
    total++;
    if ({stall, req_v} !== 2'b11 || req_addr !== 32'h400) begin
      bad++; $display("FAIL lhu_req got=%0b%0b %08h exp=11 00000400", stall, req_v, req_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({stall, req_v, wb_v} !== 3'b100) begin
        bad++; $display("FAIL lhu_wait%0d got=%03b exp=100", i, {stall, req_v, wb_v});
      end
    end
    tick();
    resp_v = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL lhu_release got=%0b exp=0", stall); end
    tick();
    resp_v = 1'b0;
    op(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 5'd6, 1'b1, 32'hCAFE0001, 32'h0);
    #1;
    total++;
    if ({wb_v, wb_rdw, wb_rd, stall} !== {2'b11, 5'd4, 1'b0} || wb_data !== 32'h00008001) begin
      bad++; $display("FAIL lhu_done got=%0b%0b/%0d/%0b %08h exp=11/4/0 00008001", wb_v, wb_rdw, wb_rd, stall, wb_data);
    end
    tick();
    idle();
    total++;
    if ({wb_v, wb_rd} !== {1'b1, 5'd6} || wb_data !== 32'hCAFE0001) begin
      bad++; $display("FAIL b2b_alu got=%0b/%0d %08h exp=1/6 cafe0001", wb_v, wb_rd, wb_data);
    end
  endtask

  task automatic test_reset_in_wait();
    tick();
    op(1'b1, 1'b1, 1'b0, 3'b010, 2'd0, 5'd8, 1'b1, 32'h500, 32'h0);
    req_ready = 1'b1;
    resp_data = 32'h5A5A5A5A;
    tick();
    tick();
    idle();
    #1;
    total++;
    if ({stall, req_v} !== 2'b10) begin
      bad++; $display("FAIL rw_inwait got=%0b%0b exp=10", stall, req_v);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({stall, req_v, wb_v, wb_rdw, wb_mis, wb_rd, wb_data} !== '0) begin
      bad++; $display("FAIL rw_zero got=%0b%0b%0b %08h exp=000 00000000", stall, req_v, wb_v, wb_data);
    end
    tick();
    #2;
    rst = 1'b1;
    tick();
    resp_v = 1'b1;
    #1;
    total++;
    if ({stall, req_v} !== 2'b00) begin
      bad++; $display("FAIL rw_ignore got=%0b%0b exp=00", stall, req_v);
    end
    tick();
    resp_v = 1'b0;
    total++;
    if ({wb_v, wb_data} !== '0) begin
      bad++; $display("FAIL rw_nowb got=%0b %08h exp=0 00000000", wb_v, wb_data);
    end
    op(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 5'd10, 1'b1, 32'h77, 32'h0);
    tick();
    idle();
    total++;
    if ({wb_v, wb_rd} !== {1'b1, 5'd10} || wb_data !== 32'h77) begin
      bad++; $display("FAIL rw_idle got=%0b/%0d %08h exp=1/10 00000077", wb_v, wb_rd, wb_data);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_sh_backpressure();
    test_misalign();
    test_back_to_back();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
